vdf_a3_fsm: RTL and testbench

Serial pattern detector for a single-bit input stream. It samples `data_in` on every rising clock edge and asserts `data_out` for exactly one cycle each time the most recent four samples form the pattern 1-1-0-1, oldest bit first. Matches may overlap. The block is a Moore state machine and is a leaf in the serial-input front end. `data_out` drives downstream logic directly.

---
 rtl/vdf_a3_pkg.sv | 41 ++++
 rtl/vdf_a3_fsm.sv | 42 ++++
 tb/tb_vdf_a3_fsm.sv | 119 +++++++++++
 3 files changed

// File: rtl/vdf_a3_pkg.sv
// ----------------------------------------------------------------------------
// vdf_a3_pkg
// Shared definitions for the 1-1-0-1 serial pattern detector.
//   vdf_a3_state_t     : detector state, 3-bit binary encoding
//   VDF_A3_PATTERN     : the detected pattern, first-received bit in the MSB
//   vdf_a3_next_state  : transition function of the detector
// ----------------------------------------------------------------------------
package vdf_a3_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,  // nothing matched
        S_1    = 3'd1,  // "1" matched
        S_11   = 3'd2,  // "11" matched
        S_110  = 3'd3,  // "110" matched
        S_HIT  = 3'd4   // "1101" matched
    } vdf_a3_state_t;

    localparam logic [3:0] VDF_A3_PATTERN = 4'b1101;

    // Transition function. Any encoding outside the five legal states
    // falls back to S_IDLE so a corrupted register recovers in one edge.
    function automatic vdf_a3_state_t vdf_a3_next_state(
        input vdf_a3_state_t cur,
        input logic          bit_in
    );
        vdf_a3_state_t nxt;
        nxt = S_IDLE;
        case (cur)
            S_IDLE:  nxt = bit_in ? S_1    : S_IDLE;
            S_1:     nxt = bit_in ? S_11   : S_IDLE;
            // A run of ones keeps the last two ones as the prefix "11".
            S_11:    nxt = bit_in ? S_11   : S_110;
            S_110:   nxt = bit_in ? S_HIT  : S_IDLE;
            // The trailing "1" of a hit plus a new "1" is already "11".
            S_HIT:   nxt = bit_in ? S_11   : S_IDLE;
            default: nxt = S_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/vdf_a3_fsm.sv
// ----------------------------------------------------------------------------
// vdf_a3_fsm
// Moore detector for the serial pattern 1-1-0-1 (oldest bit first), with
// overlapping matches. data_out is high for one cycle after the fourth
// pattern bit is sampled.
// Ports:
//   clk      : single clock, rising edge
//   reset    : synchronous, active-low reset
//   data_in  : serial data bit, sampled each rising edge
//   data_out : registered detection flag, high only while in S_HIT
// ----------------------------------------------------------------------------
module vdf_a3_fsm
    import vdf_a3_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic data_in,
    output logic data_out
);

    vdf_a3_state_t state_r;
    vdf_a3_state_t next_state_s;
    logic          data_out_r;

    assign next_state_s = vdf_a3_next_state(state_r, data_in);

    // State register and flag register; the flag is loaded with the decode
    // of the state being entered, so it always equals (state_r == S_HIT)
    // and data_in never reaches data_out combinationally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            data_out_r <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            data_out_r <= (next_state_s == S_HIT);
        end
    end

    assign data_out = data_out_r;

endmodule

// File: tb/tb_vdf_a3_fsm.sv
// ----------------------------------------------------------------------------
// tb_vdf_a3_fsm
// Scoreboard bench for vdf_a3_fsm. The stimulus process drives one sample
// per cycle and queues the hand-computed data_out expected after that edge;
// the monitor pops one entry per cycle and compares.
// ----------------------------------------------------------------------------
module tb_vdf_a3_fsm;
    import vdf_a3_pkg::*;

    logic clk;
    logic reset;
    logic data_in;
    logic data_out;

    int   n_pass;
    int   n_total;
    bit   exp_q[$];

    vdf_a3_fsm dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one sample at the falling edge; queue data_out expected after
    // the next rising edge.
    task automatic apply(input logic r, input logic d, input bit e);
        @(negedge clk);
        reset   = r;
        data_in = d;
        exp_q.push_back(e);
    endtask

    // Feed a bit string (MSB first) with its expected output string.
    task automatic apply_seq(input int len, input logic [31:0] bits, input logic [31:0] exps);
        for (int i = len - 1; i >= 0; i--) begin
            apply(1'b1, bits[i], exps[i]);
        end
    endtask

    // Monitor: one comparison per cycle, 1 ns after the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                bit e;
                e = exp_q.pop_front();
                n_total++;
                if (data_out === e) begin
                    n_pass++;
                end else begin
                    $display("FAIL data_out at %0t: got %b expected %b", $time, data_out, e);
                end
            end
        end
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b0;
        data_in = 1'b1;

        // Reset for two edges with data_in = 1.
        apply(1'b0, 1'b1, 1'b0);
        apply(1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        n_total++;
        if (dut.state_r === S_IDLE) begin
            n_pass++;
        end else begin
            $display("FAIL reset_state: got %0d expected %0d", dut.state_r, S_IDLE);
        end

        // Single match: 1,1,0,1,0
        apply_seq(5, 32'b11010, 32'b00010);
        // Overlap: 1,1,0,1,1,0,1,0 -> hits after bits 4 and 7
        apply_seq(8, 32'b11011010, 32'b00010010);
        // Non-match: 1,0,1,1,0,0
        apply_seq(6, 32'b101100, 32'b000000);
        // 1,1,1,1,0,1 then 0: single hit after the final 1
        apply_seq(7, 32'b1111010, 32'b0000010);

        // Reset mid-match: 1,1,0, reset, 1 -> no hit
        apply_seq(3, 32'b110, 32'b000);
        apply(1'b0, 1'b1, 1'b0);
        apply_seq(2, 32'b10, 32'b00);
        // Fresh full pattern after the reset still detects
        apply_seq(5, 32'b11010, 32'b00010);

        // Long idle on 0, then detect
        apply_seq(20, 32'h0, 32'h0);
        apply_seq(4, 32'b1101, 32'b0001);
        // Long run of 1 (state held in S_11), no hit
        apply_seq(20, 32'hFFFFF, 32'h0);
        // From S_11: 0,0 returns to idle, then 1101,0 detects
        apply_seq(7, 32'b0011010, 32'b0000010);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        #3;
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
